hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Purpose: per-register countdown scoreboard deciding the ID-stage stall for variable-latency producers.
// Latency: stall/stall_br are combinational from ID inputs and registered counters; counters update each edge.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; counters keep draining so every stall self-releases.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_REGS   = 2**REG_ADDR_W,
  parameter int LAT_W      = 3,
  parameter int BR_EXTRA   = 1,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic                  id_br,
  input  logic                  id_st,
  input  logic                  id_rw,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  flush,
  input  logic                  sb_clear,
  output logic                  stall,
  output logic                  stall_br,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int LAT_MAX = 2**LAT_W - 1;

  // Entry 0 exists only to keep indexing simple; it is forced to zero and never read as busy.
  logic [LAT_W-1:0]  cnt_q  [NUM_REGS];
  logic [LAT_W-1:0]  cnt_d  [NUM_REGS];
  logic [LAT_W-1:0]  bcnt_q [NUM_REGS];
  logic [LAT_W-1:0]  bcnt_d [NUM_REGS];
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] stall_cycles_d;

  logic rs_act, rt_act;
  logic rs_alu_wait, rt_alu_wait, rs_br_wait, rt_br_wait;
  logic alu_wait, any_wait, issue, do_load;
  logic [LAT_W-1:0] bcnt_ld;
  int   br_sum;

  // Hazard decision from pre-update counters; store data in rt is forwarded one stage later, so it tolerates cnt==1.
  always_comb begin
    rs_act      = id_use_rs && (id_rs != '0);
    rt_act      = id_use_rt && (id_rt != '0);
    rs_alu_wait = rs_act && (cnt_q[id_rs] != '0);
    rt_alu_wait = rt_act && (id_st ? (cnt_q[id_rt] > LAT_W'(1)) : (cnt_q[id_rt] != '0));
    rs_br_wait  = rs_act && (bcnt_q[id_rs] != '0);
    rt_br_wait  = rt_act && (bcnt_q[id_rt] != '0);
    alu_wait    = rs_alu_wait || rt_alu_wait;
    any_wait    = id_br ? (rs_br_wait || rt_br_wait) : alu_wait;
    stall       = id_valid && !flush && any_wait;
    stall_br    = stall && !alu_wait;
    issue       = id_valid && !stall && !flush;
    do_load     = issue && id_rw && (id_rd != '0) && !sb_clear;
    br_sum      = int'(id_lat) + BR_EXTRA;
    bcnt_ld     = (br_sum > LAT_MAX) ? LAT_W'(LAT_MAX) : LAT_W'(br_sum);
  end

  // Next counter state: clear beats issue load, issue load beats the per-cycle decrement.
  always_comb begin
    cnt_d[0]  = '0;
    bcnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_d[r]  = (cnt_q[r]  != '0) ? cnt_q[r]  - LAT_W'(1) : '0;
      bcnt_d[r] = (bcnt_q[r] != '0) ? bcnt_q[r] - LAT_W'(1) : '0;
      if (sb_clear) begin
        cnt_d[r]  = '0;
        bcnt_d[r] = '0;
      end else if (do_load && (id_rd == REG_ADDR_W'(r))) begin
        cnt_d[r]  = id_lat;
        bcnt_d[r] = bcnt_ld;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r]  <= '0;
        bcnt_q[r] <= '0;
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r]  <= cnt_d[r];
        bcnt_q[r] <= bcnt_d[r];
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: stimulus pushes hand-computed stall/stall_br per cycle into a queue,
// a negedge monitor pops and compares against the DUT outputs, including the stall-cycle counter.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_br, id_st, id_rw;
  logic [2:0] id_lat;
  logic       flush, sb_clear;
  logic       stall, stall_br;
  logic [15:0] stall_cycles;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_br(id_br), .id_st(id_st), .id_rw(id_rw), .id_rd(id_rd), .id_lat(id_lat),
    .flush(flush), .sb_clear(sb_clear),
    .stall(stall), .stall_br(stall_br), .stall_cycles(stall_cycles)
  );

  typedef struct {
    string       nm;
    logic        st;
    logic        br;
    logic [15:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_sc = 16'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need $finish)");
    $fatal(1);
  end

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (stall !== e.st) begin
        n_bad++;
        $display("FAIL %s stall: got %b need %b", e.nm, stall, e.st);
      end
      n_cmp++;
      if (stall_br !== e.br) begin
        n_bad++;
        $display("FAIL %s stall_br: got %b need %b", e.nm, stall_br, e.br);
      end
      n_cmp++;
      if (stall_cycles !== e.sc) begin
        n_bad++;
        $display("FAIL %s stall_cycles: got %0d need %0d", e.nm, stall_cycles, e.sc);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_br = 0; id_st = 0; id_rw = 0; id_rd = 0; id_lat = 0;
    flush = 0; sb_clear = 0;
  endtask

  task automatic prod(input logic [3:0] rd, input logic [2:0] lat);
    idle();
    id_valid = 1; id_rw = 1; id_rd = rd; id_lat = lat;
  endtask

  task automatic cons(input logic [3:0] rs, input logic urs, input logic [3:0] rt, input logic urt);
    idle();
    id_valid = 1; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
  endtask

  // Push the expectation for the current cycle, advance the counter model, move to the next cycle.
  task automatic step(input string nm, input logic es, input logic eb);
    exp_t e;
    e.nm = nm; e.st = es; e.br = eb; e.sc = exp_sc;
    exp_q.push_back(e);
    if (!rst_n) exp_sc = 16'd0;
    else if (es && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    #1;
    step("reset", 0, 0);
    rst_n = 1;

    // load-use
    prod(5, 1);          step("ld_r5", 0, 0);
    cons(5, 1, 0, 0);    step("add_r5_wait", 1, 0);
                         step("add_r5_go", 0, 0);

    // multiply chain, 3 stall cycles
    prod(3, 3);          step("mul_r3", 0, 0);
    cons(3, 1, 3, 1);
    for (int i = 0; i < 3; i++) step("use_r3_wait", 1, 0);
                         step("use_r3_go", 0, 0);

    // branch on ALU result: only the branch-extra cycle
    prod(7, 0);          step("alu_r7", 0, 0);
    cons(7, 1, 1, 1); id_br = 1;
                         step("beq_r7_wait", 1, 1);
                         step("beq_r7_go", 0, 0);

    // branch on multiply: two ALU-rule cycles then one branch-only cycle
    prod(6, 2);          step("mul_r6", 0, 0);
    cons(6, 1, 0, 0); id_br = 1;
                         step("beq_r6_a", 1, 0);
                         step("beq_r6_b", 1, 0);
                         step("beq_r6_c", 1, 1);
                         step("beq_r6_go", 0, 0);

    // store data forwarding
    prod(4, 1);          step("ld_r4_l1", 0, 0);
    cons(0, 1, 4, 1); id_st = 1;
                         step("sw_r4_l1", 0, 0);
    prod(4, 2);          step("ld_r4_l2", 0, 0);
    cons(0, 1, 4, 1); id_st = 1;
                         step("sw_r4_l2_wait", 1, 0);
                         step("sw_r4_l2_go", 0, 0);

    // r0 and unused source
    prod(0, 3);          step("mul_r0", 0, 0);
    cons(0, 1, 0, 1);    step("use_r0", 0, 0);
    prod(9, 3);          step("mul_r9", 0, 0);
    cons(1, 1, 9, 0);    step("rt_unused", 0, 0);

    // self dependence and overwrite with shorter latency
    prod(8, 3); id_rs = 8; id_use_rs = 1;
                         step("self_r8", 0, 0);
    prod(10, 3);         step("mul_r10", 0, 0);
    prod(10, 0);         step("alu_r10", 0, 0);
    cons(10, 1, 0, 0);   step("use_r10", 0, 0);

    // sb_clear drops state and suppresses the concurrent load
    prod(2, 3);          step("ld_r2", 0, 0);
    prod(11, 3); sb_clear = 1;
                         step("clear", 0, 0);
    cons(2, 1, 11, 1);   step("use_r2_r11", 0, 0);

    // flush with a hazard present: no stall, no load
    prod(12, 3);         step("mul_r12", 0, 0);
    prod(13, 3); id_rs = 12; id_use_rs = 1; flush = 1;
                         step("flush_hz", 0, 0);
    cons(13, 1, 0, 0);   step("use_r13", 0, 0);

    // branch counter saturates at max: 7 cycles, never branch-only
    prod(15, 7);         step("mul_r15", 0, 0);
    cons(15, 1, 0, 0); id_br = 1;
    for (int i = 0; i < 7; i++) step("beq_r15_wait", 1, 0);
                         step("beq_r15_go", 0, 0);

    // reset mid-stall
    prod(14, 3);         step("mul_r14", 0, 0);
    cons(14, 1, 0, 0);   step("use_r14_wait", 1, 0);
    rst_n = 0;           step("rst_mid", 1, 0);
                         step("rst_hold", 0, 0);
    rst_n = 1;           step("post_rst", 0, 0);

    idle();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
